// File: rtl/gas_alarm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : gas_alarm_controller_if
// Description : Signal bundle between the gas detector side and the alarm
//               controller: detector code and user ack in, alarm status and
//               actuator drives out.
// Revision    : 1.0  initial release
// ============================================================================
interface gas_alarm_controller_if;
    logic [2:0] gas_code;
    logic       ack;
    logic [2:0] alarm_type;
    logic       alarm_irq;
    logic       buzzer;
    logic       fan_on;
    logic       valve_close;
    logic [1:0] state;

    // Environment / detector side
    modport master (
        output gas_code, ack,
        input  alarm_type, alarm_irq, buzzer, fan_on, valve_close, state
    );

    // Controller side
    modport slave (
        input  gas_code, ack,
        output alarm_type, alarm_irq, buzzer, fan_on, valve_close, state
    );
endinterface
`default_nettype wire

// File: rtl/gas_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : gas_alarm_controller
// Description : Filters the detector gas code with per-gas persistence
//               counters, latches confirmed gases into a sticky alarm mask and
//               drives buzzer, exhaust fan and valve shutoff until the alarm is
//               acknowledged and the air stays clear long enough.
// Revision    : 1.0  initial release
// ============================================================================
module gas_alarm_controller #(
    parameter int unsigned CONFIRM_CYCLES = 4,
    parameter int unsigned CLEAR_CYCLES   = 8,
    parameter int unsigned BEEP_HALF      = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    gas_alarm_controller_if.slave   bus
);

    localparam logic [7:0] C_CONFIRM = 8'(CONFIRM_CYCLES);
    localparam logic [7:0] C_CLEAR   = 8'(CLEAR_CYCLES);
    localparam logic [7:0] C_BEEP    = 8'(BEEP_HALF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MONITOR = 2'b01,
        ST_ALARM   = 2'b10,
        ST_VENT    = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_alarm_type;
    logic [2:0] w_type_nxt;
    logic       r_irq;
    logic       w_irq_nxt;
    logic       r_buzzer;
    logic       w_buzzer_nxt;
    logic       r_fan;
    logic       w_fan_nxt;
    logic       r_valve;
    logic       w_valve_nxt;
    logic [7:0] r_clr_cnt;
    logic [7:0] w_clr_nxt;
    logic [7:0] w_clr_inc;
    logic [7:0] r_beep_cnt;
    logic [7:0] w_beep_nxt;
    logic       w_clear_all;
    logic [2:0] w_confirmed;
    logic [2:0] w_new_mask;

    // One saturating persistence counter per gas bit
    for (genvar gi = 0; gi < 3; gi++) begin : g_filter
        logic [7:0] r_cnt;

        // Count consecutive high samples of this bit, cleared by any low sample
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                r_cnt <= 8'd0;
            end else if (w_clear_all || !bus.gas_code[gi]) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != C_CONFIRM) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign w_confirmed[gi] = (r_cnt == C_CONFIRM);
    end

    // Only gases not yet latched may raise a new alarm event
    assign w_new_mask = w_confirmed & ~r_alarm_type;

    // Clear-air run length candidate; saturates rather than wrapping
    assign w_clr_inc = (bus.gas_code != 3'b000) ? 8'd0 :
                       ((r_clr_cnt == 8'hFF) ? 8'hFF : r_clr_cnt + 8'd1);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_type_nxt   = r_alarm_type;
        w_irq_nxt    = 1'b0;
        w_buzzer_nxt = 1'b0;
        w_beep_nxt   = 8'd0;
        w_clr_nxt    = 8'd0;
        w_clear_all  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.gas_code != 3'b000) begin
                    w_state_nxt = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (w_new_mask != 3'b000) begin
                    w_state_nxt  = ST_ALARM;
                    w_type_nxt   = r_alarm_type | w_new_mask;
                    w_irq_nxt    = 1'b1;
                    w_buzzer_nxt = 1'b1;
                    w_beep_nxt   = 8'd1;
                end else if (bus.gas_code == 3'b000) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (w_new_mask != 3'b000) begin
                    w_type_nxt = r_alarm_type | w_new_mask;
                    w_irq_nxt  = 1'b1;
                end
                // A fresh confirmation outranks the acknowledge
                if (w_new_mask == 3'b000 && bus.ack) begin
                    w_state_nxt = ST_VENT;
                end else if (r_beep_cnt >= C_BEEP) begin
                    w_buzzer_nxt = ~r_buzzer;
                    w_beep_nxt   = 8'd1;
                end else begin
                    w_buzzer_nxt = r_buzzer;
                    w_beep_nxt   = r_beep_cnt + 8'd1;
                end
            end
            ST_VENT: begin
                w_clr_nxt = w_clr_inc;
                if (w_new_mask != 3'b000) begin
                    w_state_nxt  = ST_ALARM;
                    w_type_nxt   = r_alarm_type | w_new_mask;
                    w_irq_nxt    = 1'b1;
                    w_buzzer_nxt = 1'b1;
                    w_beep_nxt   = 8'd1;
                    w_clr_nxt    = 8'd0;
                end else if (w_clr_inc == C_CLEAR) begin
                    w_state_nxt = ST_IDLE;
                    w_type_nxt  = 3'b000;
                    w_clr_nxt   = 8'd0;
                    w_clear_all = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_fan_nxt   = (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_VENT);
        w_valve_nxt = w_type_nxt[0];
    end

    // State and registered outputs; reset discards any alarm in progress
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_alarm_type <= 3'b000;
            r_irq        <= 1'b0;
            r_buzzer     <= 1'b0;
            r_fan        <= 1'b0;
            r_valve      <= 1'b0;
            r_clr_cnt    <= 8'd0;
            r_beep_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_alarm_type <= w_type_nxt;
            r_irq        <= w_irq_nxt;
            r_buzzer     <= w_buzzer_nxt;
            r_fan        <= w_fan_nxt;
            r_valve      <= w_valve_nxt;
            r_clr_cnt    <= w_clr_nxt;
            r_beep_cnt   <= w_beep_nxt;
        end
    end

    assign bus.state       = r_state;
    assign bus.alarm_type  = r_alarm_type;
    assign bus.alarm_irq   = r_irq;
    assign bus.buzzer      = r_buzzer;
    assign bus.fan_on      = r_fan;
    assign bus.valve_close = r_valve;

endmodule
`default_nettype wire
